// File: rtl/fifo_wr_fsm_pkg.sv
// rtl/fifo_wr_fsm_pkg.sv - shared sizing for the voq_in ping-pong FIFO write and read FSMs
package fifo_wr_fsm_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int PORT_NUB_TOTAL  = 4;
    localparam int DATA_LENGTH_MAX = 8;

    // FIFO word is {last, dest, data}; last sits at the MSB so the reader can slice it directly
    function automatic int fifo_width(input int data_width, input int width_sel);
        return width_sel + data_width + 1;
    endfunction

    function automatic int last_pos(input int data_width, input int width_sel);
        return width_sel + data_width;
    endfunction

endpackage

// File: rtl/fifo_wr_fsm_pkt_len_chk.sv
// rtl/fifo_wr_fsm_pkt_len_chk.sv - beat counter, length limit and sop/eop framing checks
module fifo_wr_fsm_pkt_len_chk
    import fifo_wr_fsm_pkg::*;
#(
    parameter int LEN_MAX      = DATA_LENGTH_MAX,
    parameter int WIDTH_LENGTH = $clog2(LEN_MAX) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic in_pkt,
    input  logic acc,
    input  logic sop,
    input  logic eop,
    output logic len_hit,
    output logic sop_err,
    output logic stray_err
);

    localparam logic [WIDTH_LENGTH-1:0] LEN_LIMIT = WIDTH_LENGTH'(LEN_MAX);
    localparam logic [WIDTH_LENGTH-1:0] ONE       = WIDTH_LENGTH'(1);

    logic [WIDTH_LENGTH-1:0] count;
    logic                    pkt_end;

    // len_hit flags the beat that would be the LEN_MAX-th one without closing the packet
    assign len_hit   = in_pkt && !eop && ((count + ONE) == LEN_LIMIT);
    assign sop_err   = in_pkt && sop;
    assign stray_err = idle && !sop;
    assign pkt_end   = eop || sop || len_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (acc) begin
            if (idle) begin
                count <= (sop && !eop) ? ONE : '0;
            end else if (in_pkt) begin
                count <= pkt_end ? '0 : count + ONE;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_fsm.sv
// rtl/fifo_wr_fsm.sv - write-side controller steering whole packets alternately into FIFO1/FIFO2
module fifo_wr_fsm
    import fifo_wr_fsm_pkg::*;
#(
    parameter int DATA_WIDTH   = fifo_wr_fsm_pkg::DATA_WIDTH,
    parameter int PORT_NUB     = PORT_NUB_TOTAL,
    parameter int WIDTH_SEL    = $clog2(PORT_NUB),
    parameter int WIDTH_FIFO   = fifo_width(DATA_WIDTH, WIDTH_SEL),
    parameter int LEN_MAX      = DATA_LENGTH_MAX,
    parameter int WIDTH_LENGTH = $clog2(LEN_MAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [WIDTH_SEL-1:0]  in_dest,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  fifo1_full,
    input  logic                  fifo2_full,
    output logic                  fifo1_wr_en,
    output logic                  fifo2_wr_en,
    output logic [WIDTH_FIFO-1:0] fifo_wr_data,
    output logic [1:0]            pkt_done_out,
    output logic                  err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 next_sel;
    logic [WIDTH_SEL-1:0] dest_reg;

    logic idle;
    logic in_pkt;
    logic tgt;
    logic cur_full;
    logic acc;
    logic wr;
    logic last;
    logic done_now;
    logic err_now;
    logic len_hit;
    logic sop_err;
    logic stray_err;

    assign idle     = (state == IDLE);
    assign in_pkt   = (state == WR1) || (state == WR2);
    // In IDLE/DROP the target is the FIFO the next packet will go to
    assign tgt      = (state == WR1) ? 1'b0 : (state == WR2) ? 1'b1 : next_sel;
    assign cur_full = tgt ? fifo2_full : fifo1_full;
    assign in_ready = (state == DROP) || !cur_full;
    assign acc      = in_valid && in_ready;

    fifo_wr_fsm_pkt_len_chk #(
        .LEN_MAX      (LEN_MAX),
        .WIDTH_LENGTH (WIDTH_LENGTH)
    ) u_pkt_len_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (idle),
        .in_pkt    (in_pkt),
        .acc       (acc),
        .sop       (in_sop),
        .eop       (in_eop),
        .len_hit   (len_hit),
        .sop_err   (sop_err),
        .stray_err (stray_err)
    );

    always_comb begin
        state_nxt    = state;
        wr           = 1'b0;
        last         = 1'b0;
        err_now      = 1'b0;
        fifo1_wr_en  = 1'b0;
        fifo2_wr_en  = 1'b0;
        fifo_wr_data = '0;

        wr       = acc && (in_pkt || (idle && in_sop));
        // A stray sop or the length limit closes the packet so the reader never sees it open
        last     = in_eop || sop_err || len_hit;
        err_now  = acc && (stray_err || sop_err || len_hit);
        done_now = wr && last;

        if (wr) begin
            fifo1_wr_en  = !tgt;
            fifo2_wr_en  = tgt;
            fifo_wr_data = {last, (idle ? in_dest : dest_reg), in_data};
        end

        case (state)
            IDLE: begin
                if (acc) begin
                    if (in_eop) begin
                        state_nxt = IDLE;
                    end else if (in_sop) begin
                        state_nxt = next_sel ? WR2 : WR1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            WR1, WR2: begin
                if (acc) begin
                    if (in_eop) begin
                        state_nxt = IDLE;
                    end else if (in_sop || len_hit) begin
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (acc && in_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            next_sel     <= 1'b0;
            dest_reg     <= '0;
            pkt_done_out <= 2'b00;
            err_out      <= 1'b0;
        end else begin
            state        <= state_nxt;
            next_sel     <= next_sel ^ done_now;
            pkt_done_out <= done_now ? (tgt ? 2'b10 : 2'b01) : 2'b00;
            err_out      <= err_now;
            if (idle && acc && in_sop) begin
                dest_reg <= in_dest;
            end
        end
    end

endmodule
